// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared font geometry, colours and welcome-screen strings
package ttt_pkg;

  localparam int FONT_ADDR_W    = 11;
  localparam int GLYPH_W        = 8;
  localparam int GLYPH_H        = 16;
  localparam int CHARS_PER_LINE = 16;
  localparam int TEXT_W         = GLYPH_W * CHARS_PER_LINE;

  localparam logic [2:0] COLOR_FG    = 3'b111;
  localparam logic [2:0] COLOR_BG    = 3'b001;
  localparam logic [2:0] COLOR_BLACK = 3'b000;

  // Index 0 is the leftmost character of each line.
  typedef logic [0:CHARS_PER_LINE-1][7:0] str16_t;

  localparam str16_t TITLE_STR  = "  TIC TAC TOE   ";
  localparam str16_t PROMPT_STR = "  PRESS START   ";

  function automatic logic [6:0] char_code(input logic line_sel, input logic [3:0] idx);
    char_code = line_sel ? PROMPT_STR[idx][6:0] : TITLE_STR[idx][6:0];
  endfunction

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - frame counter toggling the prompt visibility every BLINK_FRAMES frames
module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  output logic blink_visible
);

  localparam int              CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_blink_visible;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt     <= '0;
      r_blink_visible <= 1'b1;
    end else if (frame_start) begin
      if (r_frame_cnt == LAST) begin
        r_frame_cnt     <= '0;
        r_blink_visible <= ~r_blink_visible;
      end else begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  assign blink_visible = r_blink_visible;

endmodule

// File: rtl/welcome_text_gen.sv
// rtl/welcome_text_gen.sv - two-line welcome text: font-ROM addressing and pixel colouring
module welcome_text_gen
  import ttt_pkg::*;
#(
  parameter int         TEXT_X0      = 256,
  parameter int         TEXT_Y0      = 208,
  parameter logic [2:0] FG           = COLOR_FG,
  parameter logic [2:0] BG           = COLOR_BG,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pixel_tick,
  input  logic                   video_on,
  input  logic [9:0]             pixel_x,
  input  logic [9:0]             pixel_y,
  input  logic [7:0]             font_word,
  output logic [FONT_ADDR_W-1:0] rom_addr,
  output logic [2:0]             rgb,
  output logic                   text_on
);

  localparam logic [9:0] X0 = 10'(TEXT_X0);
  localparam logic [9:0] Y0 = 10'(TEXT_Y0);

  logic [9:0]             w_dx;
  logic [9:0]             w_dy;
  logic                   w_in_x;
  logic                   w_in_y;
  logic                   w_in_region;
  logic                   w_line;
  logic [FONT_ADDR_W-1:0] w_addr;
  logic                   w_frame_start;
  logic                   w_blink_visible;
  logic                   w_lit;

  logic [FONT_ADDR_W-1:0] r_rom_addr;
  logic [2:0]             r_col_a;
  logic                   r_in_a;
  logic                   r_line_a;
  logic                   r_video_a;
  logic [2:0]             r_rgb;
  logic                   r_text_on;

  // The >= guards stop coordinates left of / above the block wrapping into it.
  assign w_dx        = pixel_x - X0;
  assign w_dy        = pixel_y - Y0;
  assign w_in_x      = (pixel_x >= X0) && (w_dx < 10'(TEXT_W));
  assign w_in_y      = (pixel_y >= Y0) &&
                       ((w_dy < 10'(GLYPH_H)) ||
                        ((w_dy >= 10'(2 * GLYPH_H)) && (w_dy < 10'(3 * GLYPH_H))));
  assign w_in_region = w_in_x && w_in_y;
  assign w_line      = w_dy[5];
  assign w_addr      = w_in_region ? {char_code(w_line, w_dx[6:3]), w_dy[3:0]}
                                   : '0;

  assign w_frame_start = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

  blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (w_frame_start),
    .blink_visible (w_blink_visible)
  );

  // Blanking only suppresses the pixel; the prompt is still addressed.
  assign w_lit = font_word[3'd7 - r_col_a] & r_in_a & (~r_line_a | w_blink_visible);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rom_addr <= '0;
      r_col_a    <= '0;
      r_in_a     <= 1'b0;
      r_line_a   <= 1'b0;
      r_video_a  <= 1'b0;
      r_rgb      <= COLOR_BLACK;
      r_text_on  <= 1'b0;
    end else if (pixel_tick) begin
      r_rom_addr <= w_addr;
      r_col_a    <= w_dx[2:0];
      r_in_a     <= w_in_region;
      r_line_a   <= w_line;
      r_video_a  <= video_on;
      r_rgb      <= !r_video_a ? COLOR_BLACK : (w_lit ? FG : BG);
      r_text_on  <= w_lit & r_video_a;
    end
  end

  assign rom_addr = r_rom_addr;
  assign rgb      = r_rgb;
  assign text_on  = r_text_on;

endmodule
